// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and entry helpers for the Huffman decoder.
// Entries store a code right-aligned behind a leading sentinel 1, e.g. "10" -> 4'b0110.
package huffman_pkg;

  localparam int unsigned SYM_W   = 4;
  localparam int unsigned ENTRY_W = 4;
  localparam int unsigned NUM_SYM = 4;

  localparam logic [ENTRY_W-1:0] SENTINEL_INIT = 4'b0001;
  // Entries with no code bits behind the sentinel; they never match.
  localparam logic [ENTRY_W-1:0] UNUSED_ZERO   = 4'b0000;
  localparam logic [ENTRY_W-1:0] UNUSED_ONE    = 4'b0001;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;
  localparam logic [1:0] StError = 2'd3;

  // Number of code bits behind the sentinel; 0 marks an unused entry.
  function automatic logic [1:0] code_len(input logic [ENTRY_W-1:0] entry);
    logic [1:0] len;
    casez (entry)
      4'b1???: len = 2'd3;
      4'b01??: len = 2'd2;
      4'b001?: len = 2'd1;
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational lookup of the shift accumulator against the four code table entries.
// Ports:
//   acc_i   - accumulator value (sentinel 1 followed by the code bits seen so far)
//   table_i - four 4-bit entries, index i at [4i+3:4i]
//   hit_o   - some used entry equals acc_i
//   idx_o   - lowest matching index
module huffman_code_match
  import huffman_pkg::*;
(
  input  logic [ENTRY_W-1:0]         acc_i,
  input  logic [NUM_SYM*ENTRY_W-1:0] table_i,
  output logic                       hit_o,
  output logic [1:0]                 idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = 2'd0;
    // Scan from the top so the lowest equal index is the one left standing.
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (code_len(table_i[ENTRY_W*i +: ENTRY_W]) != 2'd0 &&
          table_i[ENTRY_W*i +: ENTRY_W] == acc_i) begin
        hit_o = 1'b1;
        idx_o = i[1:0];
      end
    end
  end

endmodule

// File: rtl/huffman_decode.sv
// Serial Huffman decoder: shifts code bits MSB first into a sentinel accumulator and
// emits SYM_BASE+i when the accumulator equals table entry i.
// Ports:
//   CLK, nRST               - clock, synchronous active-low reset
//   TABLE_LOAD, CODE_TABLE  - load strobe and 16-bit code table
//   BIT_IN/VALID/READY      - code bit input handshake
//   SYM_OUT/VALID/READY     - decoded symbol output handshake
//   SYM_CNT                 - wrapping count of symbols taken by the sink
//   ERR                     - sticky undecodable-pattern flag (cleared by TABLE_LOAD)
module huffman_decode
  import huffman_pkg::*;
#(
  parameter logic [3:0]  SYM_BASE = 4'hA,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             TABLE_LOAD,
  input  logic [15:0]      CODE_TABLE,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  output logic             BIT_READY,
  output logic [3:0]       SYM_OUT,
  output logic             SYM_VALID,
  input  logic             SYM_READY,
  output logic [CNT_W-1:0] SYM_CNT,
  output logic             ERR
);

  logic [1:0]         state_q, state_d;
  logic [15:0]        table_q, table_d;
  logic [3:0]         acc_q, acc_d;
  logic [3:0]         sym_out_q, sym_out_d;
  logic               sym_valid_q, sym_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [3:0]         acc_shift;
  logic               match_hit;
  logic [1:0]         match_idx;
  logic               bit_accept;

  // A load cycle never accepts a bit, even when already in StShift.
  assign BIT_READY  = (state_q == StShift) && !TABLE_LOAD;
  assign bit_accept = BIT_VALID && BIT_READY;
  assign acc_shift  = {acc_q[2:0], BIT_IN};

  huffman_code_match u_match (
    .acc_i   (acc_shift),
    .table_i (table_q),
    .hit_o   (match_hit),
    .idx_o   (match_idx)
  );

  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    acc_d       = acc_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = sym_valid_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    if (TABLE_LOAD) begin
      table_d     = CODE_TABLE;
      acc_d       = SENTINEL_INIT;
      sym_valid_d = 1'b0;
      err_d       = 1'b0;
      cnt_d       = '0;
      state_d     = StShift;
    end else begin
      case (state_q)
        StShift: begin
          if (bit_accept) begin
            if (match_hit) begin
              sym_out_d   = SYM_BASE + {2'b00, match_idx};
              sym_valid_d = 1'b1;
              acc_d       = SENTINEL_INIT;
              state_d     = StEmit;
            end else if (acc_shift[3]) begin
              // Sentinel reached the top: three bits seen and none matched.
              err_d   = 1'b1;
              acc_d   = SENTINEL_INIT;
              state_d = StError;
            end else begin
              acc_d = acc_shift;
            end
          end
        end
        StEmit: begin
          if (sym_valid_q && SYM_READY) begin
            sym_valid_d = 1'b0;
            cnt_d       = cnt_q + CNT_W'(1);
            state_d     = StShift;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= StIdle;
      table_q     <= '0;
      acc_q       <= SENTINEL_INIT;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      acc_q       <= acc_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign SYM_OUT   = sym_out_q;
  assign SYM_VALID = sym_valid_q;
  assign SYM_CNT   = cnt_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_huffman_decode.sv
// Bench for huffman_decode: directed scenarios plus randomized traffic, checked every
// cycle against a code-string reference model.
module tb_huffman_decode;

  localparam int ST_IDLE  = 0;
  localparam int ST_SHIFT = 1;
  localparam int ST_EMIT  = 2;
  localparam int ST_ERROR = 3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        TABLE_LOAD;
  logic [15:0] CODE_TABLE;
  logic        BIT_IN;
  logic        BIT_VALID;
  logic        BIT_READY;
  logic [3:0]  SYM_OUT;
  logic        SYM_VALID;
  logic        SYM_READY;
  logic [7:0]  SYM_CNT;
  logic        ERR;

  always #5 CLK = ~CLK;

  huffman_decode #(
    .SYM_BASE (4'hA),
    .CNT_W    (8)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .TABLE_LOAD (TABLE_LOAD),
    .CODE_TABLE (CODE_TABLE),
    .BIT_IN     (BIT_IN),
    .BIT_VALID  (BIT_VALID),
    .BIT_READY  (BIT_READY),
    .SYM_OUT    (SYM_OUT),
    .SYM_VALID  (SYM_VALID),
    .SYM_READY  (SYM_READY),
    .SYM_CNT    (SYM_CNT),
    .ERR        (ERR)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: codes as (length, value) pairs, bits collected as a number.
  logic [3:0] m_tab [4];
  int         m_val, m_len, m_st, m_cnt;
  logic [3:0] m_out;
  logic       m_valid, m_err;
  logic [3:0] got_syms [$];

  function automatic void entry_code(input logic [3:0] e, output int len, output int val);
    len = 0;
    val = 0;
    for (int b = 3; b >= 0; b--) begin
      if (e[b]) begin
        len = b;
        val = int'(e) % (1 << b);
        break;
      end
    end
  endfunction

  task automatic model_edge(input logic rst, input logic load, input logic [15:0] tab,
                            input logic bv, input logic b, input logic sr);
    int hit, l, v;
    if (!rst) begin
      for (int i = 0; i < 4; i++) m_tab[i] = 4'h0;
      m_val = 0; m_len = 0; m_st = ST_IDLE; m_cnt = 0;
      m_out = 4'h0; m_valid = 1'b0; m_err = 1'b0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) m_tab[i] = tab[4*i +: 4];
      m_val = 0; m_len = 0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_st = ST_SHIFT;
    end else if (m_st == ST_SHIFT && bv) begin
      m_val = m_val * 2 + int'(b);
      m_len++;
      hit = -1;
      for (int i = 0; i < 4; i++) begin
        entry_code(m_tab[i], l, v);
        if (hit < 0 && l == m_len && v == m_val) hit = i;
      end
      if (hit >= 0) begin
        m_out = 4'(10 + hit);
        m_valid = 1'b1; m_val = 0; m_len = 0; m_st = ST_EMIT;
      end else if (m_len == 3) begin
        m_err = 1'b1; m_val = 0; m_len = 0; m_st = ST_ERROR;
      end
    end else if (m_st == ST_EMIT && sr) begin
      m_valid = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
      m_st = ST_SHIFT;
    end
  endtask

  task automatic step(input logic rst, input logic load, input logic [15:0] tab,
                      input logic bv, input logic b, input logic sr);
    nRST = rst; TABLE_LOAD = load; CODE_TABLE = tab;
    BIT_VALID = bv; BIT_IN = b; SYM_READY = sr;
    #1;
    if (load) check_eq("ready_in_load", 32'(BIT_READY), 32'h0);
    if (rst && !load && SYM_VALID && sr) got_syms.push_back(SYM_OUT);
    @(posedge CLK);
    model_edge(rst, load, tab, bv, b, sr);
    #1;
    nRST = 1'b1; TABLE_LOAD = 1'b0; BIT_VALID = 1'b0;
    #1;
    check_eq("bit_ready", 32'(BIT_READY), 32'(m_st == ST_SHIFT));
    check_eq("sym_valid", 32'(SYM_VALID), 32'(m_valid));
    check_eq("sym_out",   32'(SYM_OUT),   32'(m_out));
    check_eq("sym_cnt",   32'(SYM_CNT),   32'(m_cnt));
    check_eq("err",       32'(ERR),       32'(m_err));
  endtask

  task automatic load_table(input logic [15:0] tab);
    step(1'b1, 1'b1, tab, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic bit_step(input logic b, input logic sr);
    step(1'b1, 1'b0, 16'h0, 1'b1, b, sr);
  endtask

  task automatic idle_step(input logic sr);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, sr);
  endtask

  // BIT_VALID held high; advance through the string only on accepted bits.
  task automatic send_stream(input string s);
    int k = 0;
    int guard = 0;
    logic acc;
    while (k < s.len() && guard < 1200) begin
      acc = (m_st == ST_SHIFT);
      bit_step(s[k] == 8'h31, 1'b1);
      if (acc) k++;
      guard++;
    end
    check_eq("stream_done", 32'(k), 32'(s.len()));
  endtask

  initial begin
    logic [3:0] exp_syms [7];
    logic [15:0] tab;
    string zeros;
    nRST = 1'b0; TABLE_LOAD = 1'b0; CODE_TABLE = 16'h0;
    BIT_IN = 1'b0; BIT_VALID = 1'b0; SYM_READY = 1'b0;

    // Reset state, then IDLE ignores bits.
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_ready", 32'(BIT_READY), 32'h0);
    check_eq("rst_cnt", 32'(SYM_CNT), 32'h0);
    bit_step(1'b0, 1'b1);
    check_eq("idle_no_sym", 32'(SYM_VALID), 32'h0);

    // Full stream: a=110 b=10 c=111 d=0.
    load_table(16'h2F6E);
    got_syms.delete();
    send_stream("1011011100100");
    idle_step(1'b1);
    idle_step(1'b1);
    exp_syms = '{4'hB, 4'hA, 4'hC, 4'hD, 4'hD, 4'hB, 4'hD};
    check_eq("stream_nsyms", 32'(got_syms.size()), 32'd7);
    for (int i = 0; i < 7 && i < got_syms.size(); i++)
      check_eq("stream_sym", 32'(got_syms[i]), 32'(exp_syms[i]));
    check_eq("stream_cnt", 32'(SYM_CNT), 32'd7);
    check_eq("stream_err", 32'(ERR), 32'h0);

    // Single bit latency and sink backpressure.
    load_table(16'h2F6E);
    bit_step(1'b0, 1'b0);
    check_eq("lat_valid", 32'(SYM_VALID), 32'h1);
    check_eq("lat_out", 32'(SYM_OUT), 32'hD);
    for (int i = 0; i < 5; i++) begin
      bit_step(1'b1, 1'b0);
      check_eq("hold_out", 32'(SYM_OUT), 32'hD);
      check_eq("hold_ready", 32'(BIT_READY), 32'h0);
      check_eq("hold_cnt", 32'(SYM_CNT), 32'h0);
    end
    idle_step(1'b1);
    check_eq("release_cnt", 32'(SYM_CNT), 32'h1);

    // Undecodable pattern and recovery.
    load_table(16'h2060);
    bit_step(1'b1, 1'b1);
    bit_step(1'b1, 1'b1);
    check_eq("pre_err", 32'(ERR), 32'h0);
    bit_step(1'b1, 1'b1);
    check_eq("err_set", 32'(ERR), 32'h1);
    check_eq("err_ready", 32'(BIT_READY), 32'h0);
    for (int i = 0; i < 3; i++) bit_step(1'b0, 1'b1);
    check_eq("err_sticky", 32'(ERR), 32'h1);
    load_table(16'h2060);
    check_eq("err_clear", 32'(ERR), 32'h0);
    check_eq("err_cnt", 32'(SYM_CNT), 32'h0);

    // Mid-code abort by a reload.
    load_table(16'h2F6E);
    bit_step(1'b1, 1'b1);
    bit_step(1'b1, 1'b1);
    load_table(16'h2F6E);
    bit_step(1'b0, 1'b0);
    check_eq("abort_valid", 32'(SYM_VALID), 32'h1);
    check_eq("abort_out", 32'(SYM_OUT), 32'hD);

    // Counter wrap after 256 symbols.
    load_table(16'h2F6E);
    zeros = "";
    for (int i = 0; i < 256; i++) zeros = {zeros, "0"};
    send_stream(zeros);
    idle_step(1'b1);
    check_eq("wrap_cnt", 32'(SYM_CNT), 32'h0);

    // Reset while a symbol is pending.
    bit_step(1'b0, 1'b0);
    check_eq("pend_valid", 32'(SYM_VALID), 32'h1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check_eq("rst2_valid", 32'(SYM_VALID), 32'h0);
    check_eq("rst2_out", 32'(SYM_OUT), 32'h0);
    check_eq("rst2_ready", 32'(BIT_READY), 32'h0);
    bit_step(1'b0, 1'b1);
    check_eq("rst2_idle", 32'(BIT_READY), 32'h0);

    // Randomized traffic with random tables, loads and resets.
    for (int r = 0; r < 40; r++) begin
      if (r % 2 == 0) begin
        tab = 16'($urandom);
      end else begin
        tab = 16'h2F6E;
        for (int s = 0; s < 4; s++) begin
          int a = $urandom_range(0, 3);
          logic [3:0] t = tab[4*s +: 4];
          tab[4*s +: 4] = tab[4*a +: 4];
          tab[4*a +: 4] = t;
        end
      end
      load_table(tab);
      for (int c = 0; c < 80; c++) begin
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0), 16'($urandom),
             ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) < 7));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
